// File: rtl/one_wire_resp_ctrl.sv
// One-Wire response framer: collects presence / received bytes per command
// and emits header + payload words into the RX FIFO, one write per 2 cycles.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start, command        command issue pulse and code (1 reset, 3 read, 4 search)
//   ow_busy               interface busy; its fall ends collection
//   presence_valid/detect presence result of a reset slot
//   rx_valid, rx_data     one received byte per pulse
//   fifo_full             RX FIFO full, stalls emission
//   fifo_write_enable     RX FIFO write strobe (registered)
//   fifo_write_data       RX FIFO write word (registered, [7:0] used)
//   resp_busy             high whenever the framer is not idle
//   cmd_dropped           sticky: start arrived while busy
module one_wire_resp_ctrl #(
    parameter int FIFO_WIDTH = 8,
    parameter int BUF_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [3:0]            command,
    input  logic                  ow_busy,
    input  logic                  presence_valid,
    input  logic                  presence_detect,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    input  logic                  fifo_full,
    output logic                  fifo_write_enable,
    output logic [FIFO_WIDTH-1:0] fifo_write_data,
    output logic                  resp_busy,
    output logic                  cmd_dropped
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int AW = $clog2(BUF_DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    localparam logic [3:0] CMD_RESET  = 4'd1;
    localparam logic [3:0] CMD_READ   = 4'd3;
    localparam logic [3:0] CMD_SEARCH = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_HEADER,
        S_GAP,
        S_PAYLOAD
    } state_t;

    state_t          state;
    logic [3:0]      cmd;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   idx;
    logic            seen_busy;
    logic            ovf;
    logic            pres;
    logic [7:0]      buf_mem [BUF_DEPTH];

    logic            collecting;
    logic            store;
    logic [CW-1:0]   cnt_nx;
    logic            ovf_nx;
    logic            pres_nx;
    logic [7:0]      hdr_nx;
    logic            cmd_ok;

    // Header of the frame as it stands after this cycle's inputs, so a byte
    // arriving in the busy-fall cycle is already counted in the header.
    function automatic logic [7:0] make_header(
        input logic [CW-1:0] c,
        input logic [3:0]    k,
        input logic          o,
        input logic          p
    );
        logic [CW-1:0] cm1;
        logic [3:0]    len;
        logic          flag;
        cm1  = c - CW'(1);
        len  = (c == '0) ? 4'h0 : cm1[3:0];
        flag = (k == CMD_RESET) ? p : (c == '0);
        return {len, k[1:0], o, flag};
    endfunction

    assign collecting = (state == S_COLLECT);
    assign store      = collecting && rx_valid && (cnt < DEPTH_C);
    assign cnt_nx     = cnt + CW'(store);
    assign ovf_nx     = ovf | (collecting && rx_valid && (cnt == DEPTH_C));
    assign pres_nx    = (collecting && presence_valid) ? presence_detect : pres;
    assign hdr_nx     = make_header(cnt_nx, cmd, ovf_nx, pres_nx);

    assign cmd_ok = (command == CMD_RESET) ||
                    (command == CMD_READ)  ||
                    (command == CMD_SEARCH);

    assign resp_busy = (state != S_IDLE);

    // Payload storage needs no reset: only indices below cnt are ever read.
    always_ff @(posedge clk) begin
        if (store) begin
            buf_mem[cnt[AW-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            cmd               <= '0;
            cnt               <= '0;
            idx               <= '0;
            seen_busy         <= 1'b0;
            ovf               <= 1'b0;
            pres              <= 1'b0;
            fifo_write_enable <= 1'b0;
            fifo_write_data   <= '0;
            cmd_dropped       <= 1'b0;
        end else begin
            fifo_write_enable <= 1'b0;
            fifo_write_data   <= '0;

            if (start && state != S_IDLE) begin
                cmd_dropped <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start && cmd_ok) begin
                        cmd       <= command;
                        cnt       <= '0;
                        idx       <= '0;
                        seen_busy <= 1'b0;
                        ovf       <= 1'b0;
                        pres      <= 1'b0;
                        state     <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    if (ow_busy) begin
                        seen_busy <= 1'b1;
                    end
                    cnt  <= cnt_nx;
                    ovf  <= ovf_nx;
                    pres <= pres_nx;
                    // The header write is decided in the busy-fall cycle so it
                    // leaves one cycle later; HEADER only holds a full-FIFO stall.
                    if (seen_busy && !ow_busy) begin
                        idx <= '0;
                        if (!fifo_full) begin
                            fifo_write_enable <= 1'b1;
                            fifo_write_data   <= FIFO_WIDTH'(hdr_nx);
                            state             <= S_GAP;
                        end else begin
                            state <= S_HEADER;
                        end
                    end
                end

                S_HEADER: begin
                    if (!fifo_full) begin
                        fifo_write_enable <= 1'b1;
                        fifo_write_data   <= FIFO_WIDTH'(hdr_nx);
                        state             <= S_GAP;
                    end
                end

                // Strobe is high during this cycle; the FIFO full flag
                // settles before the next write is decided.
                S_GAP: begin
                    if (idx < cnt) begin
                        state <= S_PAYLOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                S_PAYLOAD: begin
                    if (!fifo_full) begin
                        fifo_write_enable <= 1'b1;
                        fifo_write_data   <= FIFO_WIDTH'(buf_mem[idx[AW-1:0]]);
                        idx               <= idx + CW'(1);
                        state             <= S_GAP;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_one_wire_resp_ctrl.sv
// Scoreboard bench for one_wire_resp_ctrl: expected FIFO words are queued
// as stimulus is driven and popped by a write monitor.
module tb_one_wire_resp_ctrl;

    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    command = '0;
    logic          ow_busy = 1'b0;
    logic          presence_valid = 1'b0;
    logic          presence_detect = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          fifo_full = 1'b0;
    logic          fifo_write_enable;
    logic [FW-1:0] fifo_write_data;
    logic          resp_busy;
    logic          cmd_dropped;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [7:0]  exp_q [$];
    int          wr_cyc [$];
    logic [7:0]  exp_w;
    bit          full_prev = 1'b0;
    bit          we_prev = 1'b0;

    one_wire_resp_ctrl #(.FIFO_WIDTH(FW), .BUF_DEPTH(16)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .command           (command),
        .ow_busy           (ow_busy),
        .presence_valid    (presence_valid),
        .presence_detect   (presence_detect),
        .rx_valid          (rx_valid),
        .rx_data           (rx_data),
        .fifo_full         (fifo_full),
        .fifo_write_enable (fifo_write_enable),
        .fifo_write_data   (fifo_write_data),
        .resp_busy         (resp_busy),
        .cmd_dropped       (cmd_dropped)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Write monitor: scoreboard pop, no write decided under full, write spacing.
    initial begin
        forever begin
            @(negedge clk);
            if (fifo_write_enable === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write got=%02h want=none", fifo_write_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (fifo_write_data !== FW'(exp_w)) begin
                        fails++;
                        $display("FAIL fifo_word got=%02h want=%02h", fifo_write_data, exp_w);
                    end
                end
                tests++;
                if (full_prev) begin
                    fails++;
                    $display("FAIL write_while_full got=1 want=0 cyc=%0d", cyc);
                end
                tests++;
                if (we_prev) begin
                    fails++;
                    $display("FAIL write_spacing got=back_to_back want=gap cyc=%0d", cyc);
                end
                wr_cyc.push_back(cyc);
            end
            we_prev   = (fifo_write_enable === 1'b1);
            full_prev = fifo_full;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] c);
        start   = 1'b1;
        command = c;
        tick();
        start   = 1'b0;
        command = '0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && resp_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        tests++;
        if (fifo_write_enable !== 1'b0 || resp_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_in we=%b busy=%b want=0,0", fifo_write_enable, resp_busy);
        end
        reset_n = 1'b1;
        tick();
        tests++;
        if (fifo_write_enable !== 1'b0) begin
            fails++;
            $display("FAIL reset_we got=%b want=0", fifo_write_enable);
        end
        tests++;
        if (fifo_write_data !== '0) begin
            fails++;
            $display("FAIL reset_data got=%02h want=00", fifo_write_data);
        end
        tests++;
        if (resp_busy !== 1'b0 || cmd_dropped !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags busy=%b drop=%b want=0,0", resp_busy, cmd_dropped);
        end
    endtask

    task automatic test_presence();
        bit ok;
        int fall;
        wr_cyc.delete();
        issue(4'd1);
        ow_busy = 1'b1;
        exp_q.push_back(8'h05);
        repeat (10) tick();
        presence_valid  = 1'b1;
        presence_detect = 1'b1;
        tick();
        presence_valid  = 1'b0;
        presence_detect = 1'b0;
        repeat (9) tick();
        tests++;
        if (resp_busy !== 1'b1) begin
            fails++;
            $display("FAIL presence_busy got=%b want=1", resp_busy);
        end
        ow_busy = 1'b0;
        fall = cyc;
        wait_idle(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL presence_drain got=timeout want=idle");
        end
        tests++;
        if (wr_cyc.size() != 1 || wr_cyc[0] != fall + 1) begin
            fails++;
            $display("FAIL presence_latency got=n%0d@%0d want=n1@%0d",
                     wr_cyc.size(), wr_cyc.size() > 0 ? wr_cyc[0] : -1, fall + 1);
        end
    endtask

    task automatic test_read3();
        bit ok;
        int fall;
        wr_cyc.delete();
        issue(4'd3);
        ow_busy = 1'b1;
        exp_q.push_back(8'h2C);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hB2);
        exp_q.push_back(8'hC3);
        repeat (3) tick();
        send_byte(8'hA1);
        tick();
        send_byte(8'hB2);
        tick();
        // Last byte lands in the same cycle busy falls.
        rx_valid = 1'b1;
        rx_data  = 8'hC3;
        ow_busy  = 1'b0;
        fall = cyc;
        tick();
        rx_valid = 1'b0;
        wait_idle(ok);
        tests++;
        if (!ok || wr_cyc.size() != 4) begin
            fails++;
            $display("FAIL read3_count got=%0d ok=%b want=4", wr_cyc.size(), ok);
        end
        for (int i = 0; i < wr_cyc.size(); i++) begin
            tests++;
            if (wr_cyc[i] != fall + 1 + 2 * i) begin
                fails++;
                $display("FAIL read3_timing[%0d] got=%0d want=%0d", i, wr_cyc[i], fall + 1 + 2 * i);
            end
        end
    endtask

    task automatic test_search_stall();
        bit ok;
        int n;
        logic [7:0] rom [8];
        rom = '{8'h28, 8'hFF, 8'h4B, 8'h46, 8'h92, 8'h15, 8'h03, 8'h6E};
        wr_cyc.delete();
        issue(4'd4);
        ow_busy = 1'b1;
        exp_q.push_back(8'h70);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(rom[i]);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            send_byte(rom[i]);
        end
        tick();
        ow_busy = 1'b0;
        for (int i = 0; i < 50 && wr_cyc.size() < 3; i++) begin
            tick();
        end
        tests++;
        if (wr_cyc.size() < 3) begin
            fails++;
            $display("FAIL search_start got=%0d want>=3", wr_cyc.size());
        end
        fifo_full = 1'b1;
        n = wr_cyc.size();
        repeat (10) tick();
        tests++;
        if (wr_cyc.size() > n + 1) begin
            fails++;
            $display("FAIL search_stall got=%0d want<=%0d", wr_cyc.size(), n + 1);
        end
        fifo_full = 1'b0;
        wait_idle(ok);
        tests++;
        if (!ok || wr_cyc.size() != 9) begin
            fails++;
            $display("FAIL search_count got=%0d ok=%b want=9", wr_cyc.size(), ok);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        wr_cyc.delete();
        issue(4'd3);
        ow_busy = 1'b1;
        exp_q.push_back(8'hFE);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
        end
        tick();
        for (int i = 0; i < 18; i++) begin
            send_byte(8'(i));
        end
        ow_busy = 1'b0;
        wait_idle(ok);
        tests++;
        if (!ok || wr_cyc.size() != 17) begin
            fails++;
            $display("FAIL overflow_count got=%0d ok=%b want=17", wr_cyc.size(), ok);
        end
    endtask

    task automatic test_no_data();
        bit ok;
        wr_cyc.delete();
        issue(4'd3);
        ow_busy = 1'b1;
        exp_q.push_back(8'h0D);
        repeat (3) tick();
        ow_busy = 1'b0;
        wait_idle(ok);
        tests++;
        if (!ok || wr_cyc.size() != 1) begin
            fails++;
            $display("FAIL no_data_count got=%0d ok=%b want=1", wr_cyc.size(), ok);
        end
    endtask

    task automatic test_no_resp();
        wr_cyc.delete();
        issue(4'd2);
        tests++;
        if (resp_busy !== 1'b0) begin
            fails++;
            $display("FAIL write_cmd_busy got=%b want=0", resp_busy);
        end
        issue(4'd9);
        tests++;
        if (resp_busy !== 1'b0) begin
            fails++;
            $display("FAIL bad_cmd_busy got=%b want=0", resp_busy);
        end
        send_byte(8'h77);
        repeat (5) tick();
        tests++;
        if (wr_cyc.size() != 0 || cmd_dropped !== 1'b0) begin
            fails++;
            $display("FAIL no_resp got=n%0d drop=%b want=n0 drop=0", wr_cyc.size(), cmd_dropped);
        end
    endtask

    task automatic test_dropped();
        bit ok;
        wr_cyc.delete();
        issue(4'd3);
        ow_busy = 1'b1;
        exp_q.push_back(8'h0C);
        exp_q.push_back(8'h5A);
        tick();
        send_byte(8'h5A);
        ow_busy = 1'b0;
        for (int i = 0; i < 50 && wr_cyc.size() < 1; i++) begin
            tick();
        end
        tests++;
        if (resp_busy !== 1'b1) begin
            fails++;
            $display("FAIL drop_busy got=%b want=1", resp_busy);
        end
        issue(4'd3);
        tests++;
        if (cmd_dropped !== 1'b1) begin
            fails++;
            $display("FAIL cmd_dropped got=%b want=1", cmd_dropped);
        end
        wait_idle(ok);
        repeat (4) tick();
        tests++;
        if (!ok || wr_cyc.size() != 2 || resp_busy !== 1'b0) begin
            fails++;
            $display("FAIL drop_frame got=n%0d busy=%b want=n2 busy=0", wr_cyc.size(), resp_busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int seen;
        issue(4'd3);
        ow_busy = 1'b1;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        tick();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        ow_busy = 1'b0;
        seen = 0;
        for (int i = 0; i < 60 && seen < 2; i++) begin
            @(negedge clk);
            if (fifo_write_enable === 1'b1) begin
                seen++;
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (seen != 2 || fifo_write_enable !== 1'b0 || resp_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid got=seen%0d we=%b busy=%b want=seen2 we=0 busy=0",
                     seen, fifo_write_enable, resp_busy);
        end
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tests++;
        if (cmd_dropped !== 1'b0) begin
            fails++;
            $display("FAIL reset_clears_drop got=%b want=0", cmd_dropped);
        end
        wr_cyc.delete();
        issue(4'd3);
        ow_busy = 1'b1;
        exp_q.push_back(8'h1C);
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h77);
        tick();
        send_byte(8'h66);
        send_byte(8'h77);
        ow_busy = 1'b0;
        wait_idle(ok);
        tests++;
        if (!ok || wr_cyc.size() != 3) begin
            fails++;
            $display("FAIL after_reset_frame got=%0d ok=%b want=3", wr_cyc.size(), ok);
        end
    endtask

    initial begin
        test_reset();
        test_presence();
        test_read3();
        test_search_stall();
        test_overflow();
        test_no_data();
        test_no_resp();
        test_dropped();
        test_reset_mid();
        repeat (4) tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL leftover_expected got=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
